// File: rtl/tt_um_hoene_led_frame_receiver.sv
// rtl/tt_um_hoene_led_frame_receiver.sv - LED frame receiver: captures 24 GRB bits, forwards the rest, latches colour at frame end
module tt_um_hoene_led_frame_receiver #(
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data,
    input  logic       in_clk,
    input  logic       in_error,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       rgb_valid,
    output logic       fwd_data,
    output logic       fwd_strobe,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(IDLE_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FORWARD = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] idle_cnt;
    logic [23:0]   shift;
    logic [4:0]    bit_cnt;
    logic [4:0]    bit_pos;
    logic          frame_end;

    // Counter holds the number of zero cycles already seen, so this cycle is the last one.
    assign frame_end = !in_clk && (state != S_IDLE) && (idle_cnt == CNT_LAST);
    assign bit_pos   = 5'd23 - bit_cnt;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idle_cnt    <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            rgb_valid   <= 1'b0;
            fwd_data    <= 1'b0;
            fwd_strobe  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rgb_valid  <= 1'b0;
            fwd_strobe <= 1'b0;

            if (in_clk) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CNT_LIMIT) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (in_clk) begin
                        state       <= S_CAPTURE;
                        shift       <= {in_data, 23'b0};
                        bit_cnt     <= 5'd1;
                        frame_error <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (frame_end) begin
                        state       <= S_IDLE;
                        frame_error <= 1'b1;
                    end else if (in_error) begin
                        state       <= S_DISCARD;
                        frame_error <= 1'b1;
                    end else if (in_clk) begin
                        // MSB-first: bit n of the frame lands at position 23-n.
                        shift[bit_pos] <= in_data;
                        bit_cnt        <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            state <= S_FORWARD;
                        end
                    end
                end
                S_FORWARD: begin
                    if (frame_end) begin
                        state     <= S_IDLE;
                        green     <= shift[23:16];
                        red       <= shift[15:8];
                        blue      <= shift[7:0];
                        rgb_valid <= 1'b1;
                    end else if (in_error) begin
                        state       <= S_DISCARD;
                        frame_error <= 1'b1;
                    end else if (in_clk) begin
                        fwd_strobe <= 1'b1;
                        fwd_data   <= in_data;
                    end
                end
                S_DISCARD: begin
                    if (frame_end) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tt_um_hoene_led_frame_receiver.md
TT_UM_HOENE_LED_FRAME_RECEIVER -- requirements
Module: tt_um_hoene_led_frame_receiver

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL provide parameter: IDLE_TIMEOUT, default 64, number of consecutive clk cycles without in_clk that ends a frame (legal range 2..255).
REQ-003 SHALL provide ports (name, direction, width, meaning):
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_data  input  1  decoded bit value from the Manchester decoder, valid when in_clk=1
- in_clk  input  1  one-cycle strobe marking one decoded bit
- in_error  input  1  one-cycle decoder error strobe
- red  output  8  latched red value
- green  output  8  latched green value
- blue  output  8  latched blue value
- rgb_valid  output  1  one-cycle pulse when red/green/blue update
- fwd_data  output  1  forwarded bit for the downstream LED
- fwd_strobe  output  1  one-cycle strobe qualifying fwd_data
- frame_error  output  1  sticky error for the current or last frame
- busy  output  1  high whenever the state is not IDLE

Function
REQ-004 SHALL implement FSM states IDLE, CAPTURE, FORWARD, DISCARD; busy = (state != IDLE).
REQ-005 IDLE: in_clk=1 SHALL enter CAPTURE, store in_data as bit 23 of a 24-bit shift register, set bit count to 1, and clear frame_error.
REQ-006 CAPTURE: each in_clk SHALL shift in_data in MSB-first; after the 24th bit the state SHALL become FORWARD.
REQ-007 Bit order SHALL be G[7:0], R[7:0], B[7:0] (first bit = green MSB).
REQ-008 FORWARD: each in_clk SHALL produce fwd_strobe=1 with fwd_data=in_data exactly one cycle later (registered, latency 1); fwd_strobe SHALL never assert outside FORWARD.
REQ-009 An idle counter SHALL clear on every cycle with in_clk=1 and increment, saturating at IDLE_TIMEOUT, on every cycle with in_clk=0; its width is ceil(log2(IDLE_TIMEOUT+1)).
REQ-010 Frame end SHALL occur at the edge ending the IDLE_TIMEOUT-th consecutive in_clk=0 cycle while state != IDLE; the state then returns to IDLE.
REQ-011 Frame end from FORWARD SHALL load red/green/blue from the shift register at that edge and SHALL drive rgb_valid=1 for exactly the following cycle.
REQ-012 Frame end from CAPTURE (fewer than 24 bits) SHALL set frame_error=1 and leave red/green/blue and rgb_valid unchanged.
REQ-013 in_error=1 in CAPTURE or FORWARD SHALL enter DISCARD and set frame_error=1; no further fwd_strobe is generated for that frame.
REQ-014 DISCARD SHALL ignore in_clk/in_data (counter behaviour still per REQ-009) and SHALL return to IDLE at frame end without updating colours.
REQ-015 in_error in IDLE or DISCARD SHALL be ignored.
REQ-016 Simultaneous in_clk and in_error SHALL be treated as error; the bit SHALL be dropped.
REQ-017 A 24th bit arriving in CAPTURE SHALL NOT be forwarded; forwarding starts with bit 25.
REQ-018 frame_error SHALL remain set until the next IDLE->CAPTURE transition or reset.

Reset
REQ-019 Reset SHALL force: state IDLE, red=green=blue=0x00, rgb_valid=0, fwd_data=0, fwd_strobe=0, frame_error=0, busy=0, idle counter 0, shift register and bit count 0.
REQ-020 Reset asserted mid-frame SHALL abandon the frame with no colour update and no rgb_valid pulse; reset takes priority over all inputs in the same cycle.

Verification
REQ-021 24 bits 0x12_34_56, then 64 idle cycles -> green=0x12, red=0x34, blue=0x56, single rgb_valid pulse, no fwd_strobe, frame_error=0.
REQ-022 32 bits (0xAA_BB_CC then 0xF0) -> 8 fwd_strobes with fwd_data 1,1,1,1,0,0,0,0 each one cycle after in_clk; after timeout green=0xAA, red=0xBB, blue=0xCC.
REQ-023 10 bits then 64 idle cycles -> frame_error=1, colours keep prior values, no rgb_valid, busy=0.
REQ-024 in_error coincident with bit 27 -> no fwd_strobe for bits 27+, frame_error=1, no colour update after timeout; next valid frame clears frame_error and updates colours.
REQ-025 Reset asserted after bit 15 -> all outputs at reset values next cycle; following full 24-bit frame updates colours normally.
REQ-026 Bits spaced 63 idle cycles apart -> frame not ended (busy=1); a 64-cycle gap ends it.
